// File: rtl/mig_tt_pkg.sv
// Shared constants, FSM state type and counter sizing for the truth-table sweeper.
package mig_tt_pkg;

  localparam int NIN  = 7;
  localparam int TT_W = 2 ** NIN;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width needed to count 0..max_out inclusive.
  function automatic int cnt_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/mig_tt_credit.sv
// Count of evaluator requests issued but not yet answered; gates new requests at MAX_OUT.
module mig_tt_credit
  import mig_tt_pkg::*;
#(
  parameter int MAX_OUT = 4,
  localparam int CW = cnt_w(MAX_OUT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          has_credit,
  output logic          empty
);

  localparam logic [CW-1:0] LIMIT = CW'(MAX_OUT);
  localparam logic [CW-1:0] ONE   = CW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + ONE;
    end else if (dec && !inc) begin
      count <= count - ONE;
    end
  end

  assign has_credit = (count < LIMIT);
  assign empty      = (count == '0);

endmodule

// File: rtl/mig_tt_sweeper.sv
// Walks an external evaluator through every input vector, builds the truth table
// and compares it against the expected table captured at start.
module mig_tt_sweeper
  import mig_tt_pkg::*;
#(
  parameter int MAX_OUT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [TT_W-1:0] expected_tt,
  output logic            ev_req_valid,
  input  logic            ev_req_ready,
  output logic [NIN-1:0]  ev_x,
  input  logic            ev_rsp_valid,
  input  logic            ev_rsp_data,
  output logic            busy,
  output logic            done,
  output logic [TT_W-1:0] tt,
  output logic            match,
  output logic            mismatch_valid,
  output logic [NIN-1:0]  first_mismatch,
  output logic            protocol_err
);

  localparam int CW = cnt_w(MAX_OUT);
  localparam logic [NIN:0]  IDX_ONE  = (NIN + 1)'(1);
  localparam logic [NIN:0]  IDX_LAST = (NIN + 1)'(TT_W - 1);
  localparam logic [CW-1:0] OUT_ONE  = CW'(1);

  state_t          state;
  logic [NIN:0]    issue_idx;
  logic [NIN:0]    rsp_idx;
  logic [TT_W-1:0] exp_q;
  logic [CW-1:0]   outstanding;
  logic            has_credit;
  logic            out_empty;
  logic            req_fire;
  logic            rsp_take;
  logic            start_ok;
  logic            flush_needed;
  logic            rsp_bad;

  // Abort blocks the request in its own cycle so nothing new is in flight once we leave ISSUE.
  assign ev_req_valid = (state == ISSUE) && !abort && has_credit && !issue_idx[NIN];
  assign ev_x         = issue_idx[NIN-1:0];
  assign req_fire     = ev_req_valid && ev_req_ready;
  assign rsp_take     = ev_rsp_valid && !out_empty;
  assign start_ok     = start && !abort && ((state == IDLE) || (state == DONE));
  assign rsp_bad      = ev_rsp_data != exp_q[rsp_idx[NIN-1:0]];
  assign match        = done && !mismatch_valid;

  // No request can fire in an abort cycle, so only a response can change the count.
  assign flush_needed = rsp_take ? (outstanding > OUT_ONE) : !out_empty;

  mig_tt_credit #(
    .MAX_OUT(MAX_OUT)
  ) u_credit (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start_ok),
    .inc       (req_fire),
    .dec       (rsp_take),
    .count     (outstanding),
    .has_credit(has_credit),
    .empty     (out_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      issue_idx      <= '0;
      rsp_idx        <= '0;
      exp_q          <= '0;
      tt             <= '0;
      mismatch_valid <= 1'b0;
      first_mismatch <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      protocol_err   <= 1'b0;
    end else begin
      if (ev_rsp_valid && out_empty) begin
        protocol_err <= 1'b1;
      end
      if (req_fire) begin
        issue_idx <= issue_idx + IDX_ONE;
      end

      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            exp_q          <= expected_tt;
            tt             <= '0;
            issue_idx      <= '0;
            rsp_idx        <= '0;
            mismatch_valid <= 1'b0;
            first_mismatch <= '0;
            protocol_err   <= 1'b0;
            done           <= 1'b0;
            busy           <= 1'b1;
            state          <= ISSUE;
          end
        end

        ISSUE: begin
          if (rsp_take) begin
            tt[rsp_idx[NIN-1:0]] <= ev_rsp_data;
            rsp_idx              <= rsp_idx + IDX_ONE;
            if (rsp_bad && !mismatch_valid) begin
              mismatch_valid <= 1'b1;
              first_mismatch <= rsp_idx[NIN-1:0];
            end
          end
          if (abort) begin
            state <= flush_needed ? FLUSH : IDLE;
            busy  <= flush_needed;
          end else if (rsp_take && (rsp_idx == IDX_LAST)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        FLUSH: begin
          if (out_empty || (rsp_take && (outstanding == OUT_ONE))) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
